map_port_arbiter: RTL

- Shares the single read port of the track-map BRAM between two requesters: the split-screen VGA renderer and the physics/collision engine's terrain probes.
- The renderer has absolute priority whenever it is fetching visible pixels.
- Physics probes are buffered in a small FIFO and issued in idle or blanking cycles. Results return in order, tagged with a probe ID.
- Sits between the renderer's map-address mux, the physics engine and the map BRAM. Everything runs in the 25 MHz pixel clock domain.

---
 rtl/map_port_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/map_port_arbiter.sv
// rtl/map_port_arbiter.sv - track-map BRAM read-port arbiter: renderer first, physics probes queued into idle cycles
module map_port_arbiter #(
  parameter int                ADDR_W       = 17,
  parameter int                DATA_W       = 4,
  parameter int                ID_W         = 2,
  parameter int                RD_LAT       = 1,
  parameter int                QDEPTH       = 4,
  parameter int                MAP_SIZE     = 76800,
  parameter logic [DATA_W-1:0] OOB_CODE     = '0,
  parameter int                STARVE_LIMIT = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vid_active,
  input  logic [ADDR_W-1:0]           vid_addr,
  output logic [DATA_W-1:0]           vid_data,
  input  logic                        q_valid,
  output logic                        q_ready,
  input  logic [ADDR_W-1:0]           q_addr,
  input  logic [ID_W-1:0]             q_id,
  output logic                        r_valid,
  output logic [DATA_W-1:0]           r_data,
  output logic [ID_W-1:0]             r_id,
  output logic [ADDR_W-1:0]           bram_addr,
  input  logic [DATA_W-1:0]           bram_dout,
  output logic [$clog2(QDEPTH):0]     q_level,
  output logic                        starve
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int LVL_W = $clog2(QDEPTH) + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(QDEPTH);
  localparam logic [CNT_W-1:0]  SAT_CNT  = CNT_W'(STARVE_LIMIT + 1);
  localparam logic [ADDR_W:0]   MAP_LIM  = (ADDR_W + 1)'(MAP_SIZE);

  logic [ADDR_W-1:0] fifo_addr [QDEPTH];
  logic [ID_W-1:0]   fifo_id   [QDEPTH];
  logic              fifo_oob  [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level, level_next;
  logic [CNT_W-1:0]  wait_cnt, wait_next;
  logic [ADDR_W-1:0] last_addr;

  logic              pipe_vld [RD_LAT];
  logic [ID_W-1:0]   pipe_id  [RD_LAT];
  logic              pipe_oob [RD_LAT];

  logic empty, push, pop, push_oob;

  assign empty    = (level == '0);
  assign push     = rst && q_valid && q_ready;
  assign pop      = rst && !vid_active && !empty;
  assign push_oob = ({1'b0, q_addr} >= MAP_LIM);
  assign q_level  = level;
  assign vid_data = bram_dout;

  // Unregistered so the renderer sees exactly the BRAM latency.
  always_comb begin
    bram_addr = last_addr;
    if (!rst)
      bram_addr = '0;
    else if (vid_active)
      bram_addr = vid_addr;
    else if (!empty)
      bram_addr = fifo_oob[rd_ptr] ? '0 : fifo_addr[rd_ptr];
  end

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + 1'b1;
    else if (!push && pop)
      level_next = level - 1'b1;
  end

  always_comb begin
    wait_next = wait_cnt;
    if (pop)
      wait_next = '0;
    else if (!empty && wait_cnt != SAT_CNT)
      wait_next = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= q_addr;
      fifo_id[wr_ptr]   <= q_id;
      fifo_oob[wr_ptr]  <= push_oob;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      q_ready   <= 1'b0;
      wait_cnt  <= '0;
      starve    <= 1'b0;
      last_addr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level     <= level_next;
      q_ready   <= (level_next != FULL_LVL);
      wait_cnt  <= wait_next;
      starve    <= starve | (wait_next == SAT_CNT);
      last_addr <= bram_addr;
    end
  end

  // Tag pipeline runs in lockstep with the BRAM read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_id[i]  <= '0;
        pipe_oob[i] <= 1'b0;
      end
    end else begin
      pipe_vld[0] <= pop;
      pipe_id[0]  <= fifo_id[rd_ptr];
      pipe_oob[0] <= fifo_oob[rd_ptr];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
        pipe_oob[i] <= pipe_oob[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else begin
      r_valid <= pipe_vld[RD_LAT-1];
      if (pipe_vld[RD_LAT-1]) begin
        r_id   <= pipe_id[RD_LAT-1];
        r_data <= pipe_oob[RD_LAT-1] ? OOB_CODE : bram_dout;
      end
    end
  end

endmodule
